mac_cam_lut: RTL and testbench

//  Learning MAC table for the CAM switch output port lookup. Sits between the packet-path header parser and the LUT register block.
//  Per packet: looks up dst MAC -> output port mask, learns src MAC -> source port. Serves register rd/wr of table entries by index.

---
 rtl/mac_cam_lut_pkg.sv | 21 ++
 rtl/mac_cam_lut_if.sv | 43 ++++
 rtl/mac_cam_lut_match.sv | 44 ++++
 rtl/mac_cam_lut.sv | 184 ++++++++++++++++++
 tb/tb_mac_cam_lut.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_cam_lut_pkg.sv
// Shared types and constants for the learning MAC lookup table.
package mac_cam_lut_pkg;

    localparam int MAC_W     = 48;
    // I/G bit of the first octet on the wire; set means group (multicast/broadcast) address.
    localparam int MCAST_BIT = 40;

    // One-hot FSM encoding.
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_COMPARE = 5'b00010,
        S_RESOLVE = 5'b00100,
        S_REG_RD  = 5'b01000,
        S_REG_WR  = 5'b10000
    } state_e;

    function automatic logic is_mcast(input logic [MAC_W-1:0] mac);
        return mac[MCAST_BIT];
    endfunction

endpackage

// File: rtl/mac_cam_lut_if.sv
// Packet-path lookup handshake plus register read/write bus of the MAC table.
interface mac_cam_lut_if #(
    parameter int NOQ = 5,
    parameter int LDB = 4
);
    logic           lookup_rdy;
    logic           lookup_req;
    logic [47:0]    lookup_dst_mac;
    logic [47:0]    lookup_src_mac;
    logic [NOQ-1:0] lookup_src_port;
    logic           lookup_ack;
    logic [NOQ-1:0] dst_ports;
    logic           lut_hit;
    logic           lut_miss;

    logic [LDB-1:0] rd_addr;
    logic           rd_req;
    logic [NOQ-1:0] rd_oq;
    logic           rd_wr_protect;
    logic [47:0]    rd_mac;
    logic           rd_ack;

    logic [LDB-1:0] wr_addr;
    logic           wr_req;
    logic [NOQ-1:0] wr_oq;
    logic           wr_protect;
    logic [47:0]    wr_mac;
    logic           wr_ack;

    modport master (
        input  lookup_rdy, lookup_ack, dst_ports, lut_hit, lut_miss,
               rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack,
        output lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_port,
               rd_addr, rd_req, wr_addr, wr_req, wr_oq, wr_protect, wr_mac
    );

    modport slave (
        output lookup_rdy, lookup_ack, dst_ports, lut_hit, lut_miss,
               rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack,
        input  lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_port,
               rd_addr, rd_req, wr_addr, wr_req, wr_oq, wr_protect, wr_mac
    );
endinterface

// File: rtl/mac_cam_lut_match.sv
// Parallel CAM compare, registered match vector, lowest-index priority encode.
module mac_cam_lut_match
    import mac_cam_lut_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                        clk,
    input  logic                        capture,
    input  logic [MAC_W-1:0]            key,
    input  logic [DEPTH-1:0][MAC_W-1:0] macs,
    input  logic [DEPTH-1:0]            valid,
    output logic                        hit,
    output logic [IDX_W-1:0]            idx
);
    logic [DEPTH-1:0] vec_q, vec_d;

    // Compare every valid entry against the key while capture is asserted.
    always_comb begin
        vec_d = vec_q;
        if (capture) begin
            for (int i = 0; i < DEPTH; i++) begin
                vec_d[i] = valid[i] && (macs[i] == key);
            end
        end
    end

    // Hold the match vector for the resolve cycle.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    // Lowest matching index wins: scan downwards so the last assignment is the lowest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec_q[i]) begin
                hit = 1'b1;
                idx = i[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/mac_cam_lut.sv
// Learning MAC table: dst lookup to port mask, src learning, register access by index.
module mac_cam_lut
    import mac_cam_lut_pkg::*;
#(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] FLOOD_MASK = {NUM_OUTPUT_QUEUES{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    mac_cam_lut_if.slave bus
);
    localparam int NOQ   = NUM_OUTPUT_QUEUES;
    localparam int LDB   = LUT_DEPTH_BITS;
    localparam int DEPTH = 1 << LDB;

    state_e                      state_q, state_d;
    logic [DEPTH-1:0][MAC_W-1:0] mac_q, mac_d;
    logic [DEPTH-1:0][NOQ-1:0]   oq_q, oq_d;
    logic [DEPTH-1:0]            prot_q, prot_d;
    logic [DEPTH-1:0]            valid;
    logic [LDB-1:0]              repl_ptr_q, repl_ptr_d;
    logic [MAC_W-1:0]            dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [NOQ-1:0]              src_port_q, src_port_d;
    logic [NOQ-1:0]              rd_oq_q, rd_oq_d;
    logic                        rd_prot_q, rd_prot_d;
    logic [MAC_W-1:0]            rd_mac_q, rd_mac_d;
    logic                        dst_hit, src_hit, dst_use;
    logic [LDB-1:0]              dst_idx, src_idx;
    logic                        free_found, vict_found;
    logic [LDB-1:0]              free_idx, vict_idx, cand;

    // An entry is live whenever it points at any output queue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) valid[i] = |oq_q[i];
    end

    mac_cam_lut_match #(.DEPTH(DEPTH), .IDX_W(LDB)) u_dst_match (
        .clk(clk), .capture(state_q == S_COMPARE), .key(dst_mac_q),
        .macs(mac_q), .valid(valid), .hit(dst_hit), .idx(dst_idx)
    );

    mac_cam_lut_match #(.DEPTH(DEPTH), .IDX_W(LDB)) u_src_match (
        .clk(clk), .capture(state_q == S_COMPARE), .key(src_mac_q),
        .macs(mac_q), .valid(valid), .hit(src_hit), .idx(src_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: lookups beat register accesses, writes beat reads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.lookup_req)  state_d = S_COMPARE;
                else if (bus.wr_req) state_d = S_REG_WR;
                else if (bus.rd_req) state_d = S_REG_RD;
            end
            S_COMPARE: state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_IDLE;
            S_REG_RD:  if (!bus.rd_req) state_d = S_IDLE;
            S_REG_WR:  if (!bus.wr_req) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs: forwarding decision during RESOLVE, register acks while in their states.
    always_comb begin
        dst_use        = dst_hit && !is_mcast(dst_mac_q);
        bus.lookup_rdy = (state_q == S_IDLE);
        bus.lookup_ack = (state_q == S_RESOLVE);
        bus.lut_hit    = 1'b0;
        bus.lut_miss   = 1'b0;
        bus.dst_ports  = '0;
        if (state_q == S_RESOLVE) begin
            bus.lut_hit   = dst_use;
            bus.lut_miss  = !dst_use;
            bus.dst_ports = (dst_use ? oq_q[dst_idx] : FLOOD_MASK) & ~src_port_q;
        end
        bus.rd_ack = (state_q == S_REG_RD);
        bus.wr_ack = (state_q == S_REG_WR);
    end

    assign bus.rd_oq         = rd_oq_q;
    assign bus.rd_wr_protect = rd_prot_q;
    assign bus.rd_mac        = rd_mac_q;

    // Table updates (register write, learning), request capture and read-data staging.
    always_comb begin
        mac_d      = mac_q;
        oq_d       = oq_q;
        prot_d     = prot_q;
        repl_ptr_d = repl_ptr_q;
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        src_port_d = src_port_q;
        rd_oq_d    = '0;
        rd_prot_d  = 1'b0;
        rd_mac_d   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        vict_found = 1'b0;
        vict_idx   = '0;
        cand       = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = i[LDB-1:0];
            end
        end
        // Victim search starts at repl_ptr and walks past protected entries.
        for (int i = 0; i < DEPTH; i++) begin
            cand = repl_ptr_q + i[LDB-1:0];
            if (!vict_found && !prot_q[cand]) begin
                vict_found = 1'b1;
                vict_idx   = cand;
            end
        end

        if (state_q == S_IDLE && bus.lookup_req) begin
            dst_mac_d  = bus.lookup_dst_mac;
            src_mac_d  = bus.lookup_src_mac;
            src_port_d = bus.lookup_src_port;
        end else if (state_q == S_IDLE && bus.wr_req) begin
            mac_d[bus.wr_addr]  = bus.wr_mac;
            oq_d[bus.wr_addr]   = bus.wr_oq;
            prot_d[bus.wr_addr] = bus.wr_protect;
        end

        if (state_q == S_RESOLVE && !is_mcast(src_mac_q)) begin
            if (src_hit) begin
                if (!prot_q[src_idx]) oq_d[src_idx] = src_port_q;
            end else if (free_found) begin
                mac_d[free_idx]  = src_mac_q;
                oq_d[free_idx]   = src_port_q;
                prot_d[free_idx] = 1'b0;
            end else if (vict_found) begin
                mac_d[vict_idx]  = src_mac_q;
                oq_d[vict_idx]   = src_port_q;
                prot_d[vict_idx] = 1'b0;
                repl_ptr_d       = vict_idx + 1'b1;
            end
        end

        if (state_d == S_REG_RD) begin
            rd_oq_d   = oq_q[bus.rd_addr];
            rd_prot_d = prot_q[bus.rd_addr];
            rd_mac_d  = mac_q[bus.rd_addr];
        end
    end

    // Table, replacement pointer and read data are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_q      <= '0;
            oq_q       <= '0;
            prot_q     <= '0;
            repl_ptr_q <= '0;
            rd_oq_q    <= '0;
            rd_prot_q  <= 1'b0;
            rd_mac_q   <= '0;
        end else begin
            mac_q      <= mac_d;
            oq_q       <= oq_d;
            prot_q     <= prot_d;
            repl_ptr_q <= repl_ptr_d;
            rd_oq_q    <= rd_oq_d;
            rd_prot_q  <= rd_prot_d;
            rd_mac_q   <= rd_mac_d;
        end
    end

    // Lookup keys are only meaningful while a lookup is in flight.
    always_ff @(posedge clk) begin
        dst_mac_q  <= dst_mac_d;
        src_mac_q  <= src_mac_d;
        src_port_q <= src_port_d;
    end
endmodule

// File: tb/tb_mac_cam_lut.sv
// Directed bench for the learning MAC table.
module tb_mac_cam_lut;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mac_cam_lut_if #(.NOQ(5), .LDB(4)) bus ();

    mac_cam_lut #(
        .NUM_OUTPUT_QUEUES(5), .LUT_DEPTH_BITS(4), .FLOOD_MASK(5'b11111)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [4:0]  port;
        logic [4:0]  exp_ports;
        logic        exp_hit;
    } lk_vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [47:0] mac;
        logic [4:0]  oq;
        logic        prot;
    } rd_vec_t;

    lk_vec_t lk_tab[10];
    rd_vec_t rd_tab[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one lookup from IDLE, check ack timing and the forwarding decision.
    task automatic do_lookup(input string tag, input logic [47:0] dst, input logic [47:0] src,
                             input logic [4:0] port, input logic [4:0] exp_ports, input logic exp_hit);
        chk({tag, " rdy"}, 64'(bus.lookup_rdy), 64'(1));
        bus.lookup_req      = 1'b1;
        bus.lookup_dst_mac  = dst;
        bus.lookup_src_mac  = src;
        bus.lookup_src_port = port;
        step();
        bus.lookup_req = 1'b0;
        chk({tag, " ack@1"}, 64'(bus.lookup_ack), 64'(0));
        step();
        chk({tag, " ack@2"}, 64'(bus.lookup_ack), 64'(1));
        chk({tag, " ports"}, 64'(bus.dst_ports), 64'(exp_ports));
        chk({tag, " hit"},   64'(bus.lut_hit), 64'(exp_hit));
        chk({tag, " miss"},  64'(bus.lut_miss), 64'(!exp_hit));
        step();
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr, input logic [47:0] mac,
                           input logic [4:0] oq, input logic prot);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        step();
        chk({tag, " rd_ack"}, 64'(bus.rd_ack), 64'(1));
        chk({tag, " rd_mac"}, 64'(bus.rd_mac), 64'(mac));
        chk({tag, " rd_oq"},  64'(bus.rd_oq), 64'(oq));
        chk({tag, " rd_prot"}, 64'(bus.rd_wr_protect), 64'(prot));
        bus.rd_req = 1'b0;
        step();
        chk({tag, " rd_ack drop"}, 64'(bus.rd_ack), 64'(0));
    endtask

    task automatic do_write(input string tag, input logic [3:0] addr, input logic [47:0] mac,
                            input logic [4:0] oq, input logic prot);
        bus.wr_req     = 1'b1;
        bus.wr_addr    = addr;
        bus.wr_mac     = mac;
        bus.wr_oq      = oq;
        bus.wr_protect = prot;
        step();
        chk({tag, " wr_ack"}, 64'(bus.wr_ack), 64'(1));
        bus.wr_req = 1'b0;
        step();
        chk({tag, " wr_ack drop"}, 64'(bus.wr_ack), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.lookup_req = 0; bus.lookup_dst_mac = '0; bus.lookup_src_mac = '0; bus.lookup_src_port = '0;
        bus.rd_req = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_mac = '0; bus.wr_oq = '0; bus.wr_protect = 0;

        lk_tab[0] = '{48'h001122334455, 48'h001122334466, 5'b00001, 5'b11110, 1'b0};
        lk_tab[1] = '{48'h001122334466, 48'h001122334477, 5'b00100, 5'b00001, 1'b1};
        lk_tab[2] = '{48'h001122334477, 48'h001122334466, 5'b00001, 5'b00100, 1'b1};
        lk_tab[3] = '{48'h01005E000001, 48'h001122334466, 5'b00001, 5'b11110, 1'b0};
        lk_tab[4] = '{48'h001122334466, 48'h001122334488, 5'b00001, 5'b00000, 1'b1};
        lk_tab[5] = '{48'h001122334488, 48'h001122334466, 5'b00010, 5'b00001, 1'b1};
        lk_tab[6] = '{48'h001122334466, 48'h001122334477, 5'b01000, 5'b00010, 1'b1};
        lk_tab[7] = '{48'h001122334477, 48'h001122334499, 5'b10000, 5'b01000, 1'b1};
        lk_tab[8] = '{48'h001122334499, 48'h01005E000002, 5'b00001, 5'b10000, 1'b1};
        lk_tab[9] = '{48'h0011223344AB, 48'h01005E000002, 5'b00010, 5'b11101, 1'b0};

        rd_tab[0] = '{4'd0, 48'h001122334466, 5'b00010, 1'b0};
        rd_tab[1] = '{4'd1, 48'h001122334477, 5'b01000, 1'b0};
        rd_tab[2] = '{4'd2, 48'h001122334488, 5'b00001, 1'b0};
        rd_tab[3] = '{4'd3, 48'h001122334499, 5'b10000, 1'b0};
        rd_tab[4] = '{4'd4, 48'h000000000000, 5'b00000, 1'b0};

        step();
        step();
        reset = 1'b0;
        step();
        chk("reset rdy",   64'(bus.lookup_rdy), 64'(1));
        chk("reset ack",   64'(bus.lookup_ack), 64'(0));
        chk("reset hit",   64'(bus.lut_hit), 64'(0));
        chk("reset miss",  64'(bus.lut_miss), 64'(0));
        chk("reset ports", 64'(bus.dst_ports), 64'(0));
        chk("reset rdack", 64'(bus.rd_ack), 64'(0));
        chk("reset wrack", 64'(bus.wr_ack), 64'(0));
        chk("reset rdmac", 64'(bus.rd_mac), 64'(0));

        for (int i = 0; i < 10; i++)
            do_lookup($sformatf("lk%0d", i), lk_tab[i].dst, lk_tab[i].src, lk_tab[i].port,
                      lk_tab[i].exp_ports, lk_tab[i].exp_hit);
        for (int i = 0; i < 5; i++)
            do_read($sformatf("rd%0d", i), rd_tab[i].addr, rd_tab[i].mac, rd_tab[i].oq, rd_tab[i].prot);

        // Protected entry keeps its port when its MAC is seen from another port.
        do_write("wr3", 4'd3, 48'h0011223344AA, 5'b00010, 1'b1);
        do_lookup("prot", 48'h001122334466, 48'h0011223344AA, 5'b01000, 5'b00010, 1'b1);
        do_read("rd3p", 4'd3, 48'h0011223344AA, 5'b00010, 1'b1);

        // Writing oq=0 frees entry 2; the next learn lands in the lowest free slot.
        do_write("wr2", 4'd2, 48'h001122334488, 5'b00000, 1'b0);
        do_lookup("inval", 48'h001122334488, 48'h0011223344BB, 5'b00100, 5'b11011, 1'b0);
        do_read("rd2l", 4'd2, 48'h0011223344BB, 5'b00100, 1'b0);

        // Lookup and read requested together: lookup first, read acked at req+4.
        bus.lookup_req = 1'b1; bus.lookup_dst_mac = 48'h01005E000001;
        bus.lookup_src_mac = 48'h001122334466; bus.lookup_src_port = 5'b00001;
        bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
        step();
        bus.lookup_req = 1'b0;
        chk("pri ack@1", 64'(bus.lookup_ack), 64'(0));
        chk("pri rdack@1", 64'(bus.rd_ack), 64'(0));
        step();
        chk("pri ack@2", 64'(bus.lookup_ack), 64'(1));
        chk("pri ports", 64'(bus.dst_ports), 64'(5'b11110));
        chk("pri miss", 64'(bus.lut_miss), 64'(1));
        chk("pri rdack@2", 64'(bus.rd_ack), 64'(0));
        step();
        chk("pri rdack@3", 64'(bus.rd_ack), 64'(0));
        step();
        chk("pri rdack@4", 64'(bus.rd_ack), 64'(1));
        chk("pri rdmac", 64'(bus.rd_mac), 64'(48'h0011223344AA));
        chk("pri rdoq", 64'(bus.rd_oq), 64'(5'b00010));
        chk("pri rdprot", 64'(bus.rd_wr_protect), 64'(1));
        step();
        chk("pri rdack hold", 64'(bus.rd_ack), 64'(1));
        bus.rd_req = 1'b0;
        step();
        chk("pri rdack drop", 64'(bus.rd_ack), 64'(0));
        chk("pri rdy", 64'(bus.lookup_rdy), 64'(1));

        // Reset while a lookup is in COMPARE.
        bus.lookup_req = 1'b1; bus.lookup_dst_mac = 48'h001122334466;
        bus.lookup_src_mac = 48'h0000000000CC; bus.lookup_src_port = 5'b00001;
        step();
        bus.lookup_req = 1'b0;
        reset = 1'b1;
        chk("rst cmp ack", 64'(bus.lookup_ack), 64'(0));
        step();
        reset = 1'b0;
        chk("rst ack@2", 64'(bus.lookup_ack), 64'(0));
        chk("rst hit@2", 64'(bus.lut_hit), 64'(0));
        chk("rst rdy", 64'(bus.lookup_rdy), 64'(1));
        step();
        chk("rst ack@3", 64'(bus.lookup_ack), 64'(0));
        do_read("rst rd0", 4'd0, 48'h0, 5'b00000, 1'b0);
        do_read("rst rd3", 4'd3, 48'h0, 5'b00000, 1'b0);

        // Fill the table, protect entry 0, then force replacements.
        for (int i = 0; i < 16; i++)
            do_lookup($sformatf("fill%0d", i), 48'h00000000FFFF, 48'h000000001000 + 48'(i),
                      5'b00001, 5'b11110, 1'b0);
        do_write("wr0p", 4'd0, 48'h000000001000, 5'b00001, 1'b1);
        do_lookup("repl1", 48'h00000000FFFF, 48'h000000002001, 5'b00010, 5'b11101, 1'b0);
        do_lookup("repl2", 48'h00000000FFFF, 48'h000000002002, 5'b00010, 5'b11101, 1'b0);
        do_lookup("repl3", 48'h00000000FFFF, 48'h000000002003, 5'b00100, 5'b11011, 1'b0);
        do_read("rpl rd0", 4'd0, 48'h000000001000, 5'b00001, 1'b1);
        do_read("rpl rd1", 4'd1, 48'h000000002001, 5'b00010, 1'b0);
        do_read("rpl rd2", 4'd2, 48'h000000002002, 5'b00010, 1'b0);
        do_read("rpl rd3", 4'd3, 48'h000000002003, 5'b00100, 1'b0);
        do_read("rpl rd4", 4'd4, 48'h000000001004, 5'b00001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
